// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: ID-stage hazard detector that tracks in-flight
// register writers in an internal shadow pipeline of DEPTH stages
// (stage 0 = EX, stage 1 = MEM, ...). hazard_detected is purely
// combinational from the scoreboard contents and the ID-stage inputs.
//
// Optional build macro HAZ_PERF_CNT_EN adds the stall_count port, a
// saturating count of unfrozen hazard cycles. Without the macro the port
// and the counter do not exist.
module hazard_scoreboard_unit #(
    parameter int REG_W    = 4,
    parameter int DEPTH    = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] src_1,
    input  logic [REG_W-1:0] src_2,
    input  logic             two_src,
    input  logic             id_wb_en,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_mem_read,
    input  logic             forwarding_mode,
    input  logic             freeze,
    input  logic             flush,
    output logic             hazard_detected
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_count
`endif
);

    // Reject parameter sets the scoreboard cannot represent.
    if (DEPTH < 1 || DEPTH > 8 || LOAD_LAT < 1 || LOAD_LAT > DEPTH || CNT_W < 1 || REG_W < 1) begin : g_param_error
        $error("hazard_scoreboard_unit: illegal parameter combination");
    end

    // Scoreboard: valid is control (reset), dest/is_load are data (no reset).
    logic [DEPTH-1:0] sb_vld;
    logic [REG_W-1:0] sb_dest [DEPTH];
    logic [DEPTH-1:0] sb_load;

    logic [DEPTH-1:0] stage_match;
    logic             any_match;
    logic             load_match;
    logic             ins_vld;

    // Per-stage source comparison; src_2 only counts when it is actually read.
    for (genvar g = 0; g < DEPTH; g++) begin : g_match
        assign stage_match[g] = sb_vld[g] &&
                                ((sb_dest[g] == src_1) || (two_src && (sb_dest[g] == src_2)));
    end

    // Collapse stage matches into "any writer" and "load inside its use window".
    always_comb begin
        any_match  = 1'b0;
        load_match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (stage_match[i]) begin
                any_match = 1'b1;
                if ((i < LOAD_LAT) && sb_load[i]) begin
                    load_match = 1'b1;
                end
            end
        end
    end

    // Forwarding only needs to wait out young loads; otherwise any writer stalls.
    always_comb begin
        hazard_detected = id_valid && (forwarding_mode ? load_match : any_match);
    end

    // A stalled or flushed ID instruction enters the shadow pipeline as a bubble.
    assign ins_vld = id_valid && id_wb_en && !hazard_detected && !flush;

    // Advance the valid bits unless the whole pipeline is frozen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_vld <= '0;
        end else if (!freeze) begin
            sb_vld[0] <= ins_vld;
            for (int i = 1; i < DEPTH; i++) begin
                sb_vld[i] <= sb_vld[i-1];
            end
        end
    end

    // Advance the dest/is_load payload in lockstep with the valid bits.
    always_ff @(posedge clk) begin
        if (!freeze) begin
            sb_dest[0] <= id_dest;
            sb_load[0] <= id_mem_read;
            for (int i = 1; i < DEPTH; i++) begin
                sb_dest[i] <= sb_dest[i-1];
                sb_load[i] <= sb_load[i-1];
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Count cycles in which the ID instruction is actually held back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
        end else if (hazard_detected && !freeze) begin
            stall_count <= sat_inc(stall_count);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit. Two instances share stimulus:
// u_dut uses defaults (DEPTH=2, LOAD_LAT=1), u_dut2 uses LOAD_LAT=2 and a
// 2-bit counter so saturation is reachable.
module tb_hazard_scoreboard_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       id_valid = 1'b0;
    logic [3:0] src_1 = '0;
    logic [3:0] src_2 = '0;
    logic       two_src = 1'b0;
    logic       id_wb_en = 1'b0;
    logic [3:0] id_dest = '0;
    logic       id_mem_read = 1'b0;
    logic       forwarding_mode = 1'b0;
    logic       freeze = 1'b0;
    logic       flush = 1'b0;
    logic       haz1;
    logic       haz2;
`ifdef HAZ_PERF_CNT_EN
    logic [15:0] cnt1;
    logic [1:0]  cnt2;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_unit #(.REG_W(4), .DEPTH(2), .LOAD_LAT(1), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .src_1(src_1), .src_2(src_2),
        .two_src(two_src), .id_wb_en(id_wb_en), .id_dest(id_dest),
        .id_mem_read(id_mem_read), .forwarding_mode(forwarding_mode),
        .freeze(freeze), .flush(flush), .hazard_detected(haz1)
`ifdef HAZ_PERF_CNT_EN
        , .stall_count(cnt1)
`endif
    );

    hazard_scoreboard_unit #(.REG_W(4), .DEPTH(2), .LOAD_LAT(2), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .src_1(src_1), .src_2(src_2),
        .two_src(two_src), .id_wb_en(id_wb_en), .id_dest(id_dest),
        .id_mem_read(id_mem_read), .forwarding_mode(forwarding_mode),
        .freeze(freeze), .flush(flush), .hazard_detected(haz2)
`ifdef HAZ_PERF_CNT_EN
        , .stall_count(cnt2)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive the ID-stage instruction and let the combinational output settle.
    task automatic set_id(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                          input logic two, input logic wb, input logic [3:0] d,
                          input logic ld);
        id_valid    = v;
        src_1       = s1;
        src_2       = s2;
        two_src     = two;
        id_wb_en    = wb;
        id_dest     = d;
        id_mem_read = ld;
        #1;
    endtask

    // Fill both shadow pipelines with bubbles.
    task automatic drain;
        freeze = 1'b0;
        flush  = 1'b0;
        set_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        repeat (2) tick;
    endtask

    initial begin
        #2;
        check_eq("reset_haz1", haz1, 0);
        check_eq("reset_haz2", haz2, 0);
`ifdef HAZ_PERF_CNT_EN
        check_eq("reset_cnt1", cnt1, 0);
        check_eq("reset_cnt2", cnt2, 0);
`endif
        rst = 1'b1;
        tick;

        // Non-forwarding: writer to R3 then a reader stalls for DEPTH cycles.
        forwarding_mode = 1'b0;
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b0);
        check_eq("nofwd_issue", haz1, 0);
        tick;
        set_id(1'b1, 4'd3, 4'd0, 1'b0, 1'b1, 4'd4, 1'b0);
        check_eq("nofwd_ex", haz1, 1);
        check_eq("nofwd_ex2", haz2, 1);
        tick;
        check_eq("nofwd_mem", haz1, 1);
        tick;
        check_eq("nofwd_clear", haz1, 0);
`ifdef HAZ_PERF_CNT_EN
        check_eq("nofwd_cnt1", cnt1, 2);
        check_eq("nofwd_cnt2", cnt2, 2);
`endif
        // Bubble in ID never hazards even if its sources match.
        tick;
        set_id(1'b0, 4'd4, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        check_eq("bubble_no_haz", haz1, 0);
        drain;

        // Forwarding: load to R5, reader via src_2.
        forwarding_mode = 1'b1;
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b1);
        tick;
        set_id(1'b1, 4'd0, 4'd5, 1'b1, 1'b1, 4'd6, 1'b0);
        check_eq("ld_use_c0_lat1", haz1, 1);
        check_eq("ld_use_c0_lat2", haz2, 1);
        tick;
        check_eq("ld_use_c1_lat1", haz1, 0);
        check_eq("ld_use_c1_lat2", haz2, 1);
        tick;
        check_eq("ld_use_c2_lat2", haz2, 0);
        drain;

        // Same load, but src_2 is unused.
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b1);
        tick;
        set_id(1'b1, 4'd0, 4'd5, 1'b0, 1'b1, 4'd6, 1'b0);
        check_eq("ld_src2_unused1", haz1, 0);
        check_eq("ld_src2_unused2", haz2, 0);
        drain;

        // Forwarding: ALU writer to R7 never stalls.
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd7, 1'b0);
        tick;
        set_id(1'b1, 4'd7, 4'd0, 1'b0, 1'b1, 4'd8, 1'b0);
        check_eq("alu_fwd_c0", haz1, 0);
        check_eq("alu_fwd_c0_2", haz2, 0);
        tick;
        check_eq("alu_fwd_c1", haz1, 0);
        drain;

        // Own dest equal to own source is not a hazard.
        forwarding_mode = 1'b0;
        set_id(1'b1, 4'd4, 4'd4, 1'b1, 1'b1, 4'd4, 1'b1);
        check_eq("self_dep", haz1, 0);
        drain;

        // Freeze holds the load in stage 0 and the hazard with it.
        forwarding_mode = 1'b1;
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b1);
        tick;
        freeze = 1'b1;
        set_id(1'b1, 4'd2, 4'd0, 1'b0, 1'b1, 4'd10, 1'b0);
        for (int k = 0; k < 3; k++) begin
            check_eq("freeze_hold", haz1, 1);
            tick;
        end
        freeze = 1'b0;
        #1;
        check_eq("unfreeze_c0", haz1, 1);
        check_eq("unfreeze_c0_2", haz2, 1);
        tick;
        check_eq("unfreeze_c1", haz1, 0);
        check_eq("unfreeze_c1_2", haz2, 1);
        tick;
        check_eq("unfreeze_c2_2", haz2, 0);
        drain;
`ifdef HAZ_PERF_CNT_EN
        check_eq("cnt1_total", cnt1, 4);
        check_eq("cnt2_saturated", cnt2, 3);
`endif

        // Flushed writer to R9 leaves no valid entry.
        forwarding_mode = 1'b0;
        flush = 1'b1;
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd9, 1'b0);
        tick;
        flush = 1'b0;
        set_id(1'b1, 4'd9, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        check_eq("flush_c0", haz1, 0);
        tick;
        check_eq("flush_c1", haz1, 0);
        drain;

        // Asynchronous reset during an active hazard.
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b0);
        tick;
        set_id(1'b1, 4'd3, 4'd0, 1'b0, 1'b1, 4'd4, 1'b0);
        check_eq("pre_rst_haz", haz1, 1);
        #1 rst = 1'b0;
        #1;
        check_eq("async_rst_haz1", haz1, 0);
        check_eq("async_rst_haz2", haz2, 0);
`ifdef HAZ_PERF_CNT_EN
        check_eq("async_rst_cnt1", cnt1, 0);
        check_eq("async_rst_cnt2", cnt2, 0);
`endif
        tick;
        rst = 1'b1;
        #1;
        check_eq("post_rst_haz", haz1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Parametrised successor to the ID-stage hazard detector.
- Tracks in-flight writers in an internal shadow pipeline of DEPTH stages (stage 0 = EX, stage 1 = MEM, ...) instead of taking per-stage dest/wb_en inputs.
- Raises hazard_detected combinationally for the instruction currently in ID.
- Supports forwarding and non-forwarding modes, multi-cycle load-use windows, freeze (memory stall) and flush.

Parameters:
- REG_W, 4, register address width (2**REG_W architectural registers).
- DEPTH, 2, tracked writer stages between ID and write-back (min 1, max 8).
- LOAD_LAT, 1, load-use window in forwarding mode: a load hazards while in stages 0..LOAD_LAT-1 (1 <= LOAD_LAT <= DEPTH).
- CNT_W, 16, width of the stall performance counter (optional feature only).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction (not a bubble).
- src_1  in  REG_W  first source register of the ID instruction.
- src_2  in  REG_W  second source register.
- two_src  in  1  src_2 is used.
- id_wb_en  in  1  ID instruction writes a register.
- id_dest  in  REG_W  ID destination register.
- id_mem_read  in  1  ID instruction is a load.
- forwarding_mode  in  1  1 = forwarding enabled.
- freeze  in  1  memory stall: whole pipeline holds.
- flush  in  1  branch taken: ID instruction discarded.
- hazard_detected  out  1  stall the ID instruction this cycle.
- stall_count  out  CNT_W  saturating count of hazard cycles (optional feature only).

Behaviour:
- Scoreboard entry per stage: {valid, dest[REG_W], is_load}.
- Reset (rst low, asynchronous): all entries invalid; hazard_detected = 0 (no valid entries); stall_count = 0.
- Stage i matches when entry[i].valid and its dest equals src_1, or equals src_2 with two_src = 1.
- No forwarding: hazard = id_valid and any stage 0..DEPTH-1 matches.
- Forwarding: hazard = id_valid and any stage i < LOAD_LAT matches with is_load = 1.
- hazard_detected is purely combinational from current state and inputs: 0-cycle latency, no registered output.
- Update when freeze = 0:
  - entry[i] <= entry[i-1] for i = 1..DEPTH-1; entry[DEPTH-1] retires.
  - entry[0] <= {id_valid & id_wb_en & ~hazard_detected & ~flush, id_dest, id_mem_read}.
  - A stalled or flushed ID instruction therefore inserts a bubble.
- Update when freeze = 1: all entries hold, regardless of flush. hazard_detected is still computed.
- Simultaneous flush and hazard: bubble inserted (same result).
- Multiple stages match: a single hazard, no priority needed.
- The ID instruction's own dest equalling its own source is not a hazard (dest is not compared against the ID stage).
- rst asserted mid-stall: entries clear immediately; hazard drops in the same cycle.
- A load with LOAD_LAT = 2 in forwarding mode stalls a dependent instruction for 2 cycles.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined: stall_count increments by 1 on each rising edge where hazard_detected = 1 and freeze = 0.
  - Saturates at 2**CNT_W-1, no wrap.
  - Cleared only by reset.
- Undefined: stall_count port is absent, and no counter logic is built.

Test Plan:
- Reset, forwarding_mode = 0: issue R3 <= ..., then next cycle ID reads src_1 = 3 -> hazard = 1 for 2 cycles (DEPTH = 2), then 0. stall_count = 2.
- forwarding_mode = 1, LOAD_LAT = 1: load to R5, next ID src_2 = 5 with two_src = 1 -> hazard for exactly 1 cycle. With two_src = 0 -> no hazard.
- forwarding_mode = 1: ALU op to R7, dependent next -> hazard stays 0 throughout.
- Load to R2 followed by dependent instruction, freeze = 1 held 3 cycles -> hazard stays 1 across the freeze. Entries unchanged; hazard clears 1 unfrozen cycle later.
- flush = 1 on an instruction writing R9 -> entry invalid. Subsequent ID src_1 = 9, forwarding_mode = 0 -> hazard = 0.
- Drive rst low during an active hazard -> hazard_detected = 0 asynchronously. Counter saturation check with CNT_W = 2: 5 stall cycles -> stall_count = 3.
